// File: rtl/mycpu_pkg.sv
// Shared CPU datapath types and helpers used by the operand/result arbiter.
package mycpu_pkg;

    // Output register occupancy of the operand/result arbiter.
    typedef enum logic [0:0] {
        IDLE,
        SEND
    } arb_state_t;

    // Mux select meaning "no source"; the mux drives zero for it.
    localparam logic [1:0] SEL_NONE = 2'b11;

    // Number of requesters feeding the operand/result mux.
    localparam int unsigned ARB_N = 3;

    // Next requester index, wrapping 2 -> 0.
    function automatic logic [1:0] arb_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // First asserted request scanning start, start+1, start+2 (mod ARB_N).
    function automatic logic [1:0] arb_pick(input logic [ARB_N-1:0] req,
                                            input logic [1:0]       start);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        idx   = start;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 0; k < ARB_N; k++) begin
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = arb_next(idx);
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_3x16.sv
// Three-input 16-bit operand/result mux; select 2'b11 yields zero.
module mux_3x16 (
    input  logic [1:0]  sel_in,
    input  logic [15:0] d0_in,
    input  logic [15:0] d1_in,
    input  logic [15:0] d2_in,
    output logic [15:0] y_out
);

    // Pure select; unused code forces zero so an idle mux does not leak data.
    always_comb begin
        y_out = 16'h0000;
        unique case (sel_in)
            2'd0:    y_out = d0_in;
            2'd1:    y_out = d1_in;
            2'd2:    y_out = d2_in;
            default: y_out = 16'h0000;
        endcase
    end

endmodule

// File: rtl/bus_arb_3x16.sv
// Round-robin / fixed-priority arbiter for the 3x16 operand/result mux with a
// single-entry registered output drained by valid/ready.
module bus_arb_3x16
    import mycpu_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req_in,
    input  logic [15:0] d0_in,
    input  logic [15:0] d1_in,
    input  logic [15:0] d2_in,
    output logic [2:0]  ack_out,
    output logic [15:0] m_out,
    output logic        out_valid_out,
    input  logic        out_ready_in,
    output logic [1:0]  sel_out,
    output logic [15:0] xfer_cnt_out
);

    arb_state_t  state_q, state_d;
    logic [1:0]  last_q;
    logic [15:0] m_q;
    logic [1:0]  sel_q;
    logic [15:0] cnt_q;

    logic        load;
    logic [1:0]  winner;
    logic [1:0]  mux_sel;
    logic [15:0] mux_y;

    // Load when anyone requests and the register is empty or draining this edge.
    assign load = (|req_in) & ((state_q == IDLE) | out_ready_in);

    // Winner selection, mux select and the one-hot accept.
    always_comb begin
        winner  = arb_pick(req_in, (FIXED_PRIO != 0) ? 2'd0 : arb_next(last_q));
        mux_sel = load ? winner : SEL_NONE;
        ack_out = 3'b000;
        if (load && rst_n) begin
            ack_out[winner] = 1'b1;
        end
    end

    mux_3x16 u_mux (
        .sel_in (mux_sel),
        .d0_in  (d0_in),
        .d1_in  (d1_in),
        .d2_in  (d2_in),
        .y_out  (mux_y)
    );

    // Next state: a load always fills; a drain without a load empties.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEND;
        end else if (state_q == SEND && out_ready_in) begin
            state_d = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register, source tag and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q    <= 16'h0000;
            sel_q  <= SEL_NONE;
            last_q <= 2'd2;
        end else if (load) begin
            m_q    <= mux_y;
            sel_q  <= winner;
            last_q <= winner;
        end else if (state_q == SEND && out_ready_in) begin
            // m_q keeps its last value once drained.
            sel_q <= SEL_NONE;
        end
    end

    // Completed downstream transfers, free-running wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else if (out_valid_out && out_ready_in) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign m_out         = m_q;
    assign sel_out       = sel_q;
    assign out_valid_out = (state_q == SEND);
    assign xfer_cnt_out  = cnt_q;

endmodule

// File: tb/tb_bus_arb_3x16.sv
// Directed bench for bus_arb_3x16: round-robin instance plus a fixed-priority
// instance sharing the same stimulus.
module tb_bus_arb_3x16;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_in;
    logic [15:0] d0_in, d1_in, d2_in;
    logic        out_ready_in;

    logic [2:0]  ack_out, fp_ack;
    logic [15:0] m_out, fp_m;
    logic        out_valid_out, fp_valid;
    logic [1:0]  sel_out, fp_sel;
    logic [15:0] xfer_cnt_out, fp_cnt;

    int n_checks;
    int n_errors;

    bus_arb_3x16 #(.FIXED_PRIO(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_in        (req_in),
        .d0_in         (d0_in),
        .d1_in         (d1_in),
        .d2_in         (d2_in),
        .ack_out       (ack_out),
        .m_out         (m_out),
        .out_valid_out (out_valid_out),
        .out_ready_in  (out_ready_in),
        .sel_out       (sel_out),
        .xfer_cnt_out  (xfer_cnt_out)
    );

    bus_arb_3x16 #(.FIXED_PRIO(1)) dut_fp (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_in        (req_in),
        .d0_in         (d0_in),
        .d1_in         (d1_in),
        .d2_in         (d2_in),
        .ack_out       (fp_ack),
        .m_out         (fp_m),
        .out_valid_out (fp_valid),
        .out_ready_in  (out_ready_in),
        .sel_out       (fp_sel),
        .xfer_cnt_out  (fp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [15:0] rr_data [6];
    logic [2:0]  rr_ack  [6];
    logic [1:0]  rr_sel  [6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rr_data = '{16'hA000, 16'hB000, 16'hC000, 16'hA000, 16'hB000, 16'hC000};
        rr_ack  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rr_sel  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

        // Reset state, with a request present that must not be acked.
        rst_n = 1'b0;
        req_in = 3'b001;
        d0_in = 16'h0000; d1_in = 16'h0000; d2_in = 16'h0000;
        out_ready_in = 1'b1;
        tick();
        check_eq("rst_m", {16'h0, m_out}, 32'h0);
        check_eq("rst_valid", {31'h0, out_valid_out}, 32'h0);
        check_eq("rst_sel", {30'h0, sel_out}, 32'h3);
        check_eq("rst_cnt", {16'h0, xfer_cnt_out}, 32'h0);
        check_eq("rst_ack", {29'h0, ack_out}, 32'h0);

        // Single requester.
        rst_n = 1'b1;
        d0_in = 16'h1234;
        settle();
        check_eq("single_ack", {29'h0, ack_out}, 32'h1);
        tick();
        req_in = 3'b000;
        check_eq("single_m", {16'h0, m_out}, 32'h1234);
        check_eq("single_sel", {30'h0, sel_out}, 32'h0);
        check_eq("single_valid", {31'h0, out_valid_out}, 32'h1);
        check_eq("single_cnt0", {16'h0, xfer_cnt_out}, 32'h0);
        settle();
        check_eq("single_noack", {29'h0, ack_out}, 32'h0);
        tick();
        check_eq("single_cnt1", {16'h0, xfer_cnt_out}, 32'h1);
        check_eq("single_empty", {31'h0, out_valid_out}, 32'h0);
        check_eq("single_selnone", {30'h0, sel_out}, 32'h3);
        check_eq("single_mhold", {16'h0, m_out}, 32'h1234);

        // Round-robin from a fresh reset: 0,1,2,0,1,2.
        rst_n = 1'b0;
        settle();
        rst_n = 1'b1;
        req_in = 3'b111;
        d0_in = 16'hA000; d1_in = 16'hB000; d2_in = 16'hC000;
        out_ready_in = 1'b1;
        settle();
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("rr_ack%0d", i), {29'h0, ack_out}, {29'h0, rr_ack[i]});
            tick();
            check_eq($sformatf("rr_m%0d", i), {16'h0, m_out}, {16'h0, rr_data[i]});
            check_eq($sformatf("rr_sel%0d", i), {30'h0, sel_out}, {30'h0, rr_sel[i]});
        end
        req_in = 3'b000;
        tick();
        check_eq("rr_cnt", {16'h0, xfer_cnt_out}, 32'd6);

        // Backpressure: fill, then stall with requester 1 waiting.
        req_in = 3'b001;
        d0_in = 16'h1111;
        out_ready_in = 1'b0;
        tick();
        check_eq("bp_fill_m", {16'h0, m_out}, 32'h1111);
        req_in = 3'b010;
        d1_in = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("bp_ack%0d", i), {29'h0, ack_out}, 32'h0);
            check_eq($sformatf("bp_m%0d", i), {16'h0, m_out}, 32'h1111);
            check_eq($sformatf("bp_sel%0d", i), {30'h0, sel_out}, 32'h0);
            tick();
        end
        check_eq("bp_cnt_hold", {16'h0, xfer_cnt_out}, 32'd6);
        out_ready_in = 1'b1;
        settle();
        check_eq("bp_release_ack", {29'h0, ack_out}, 32'h2);
        tick();
        req_in = 3'b000;
        check_eq("bp_new_m", {16'h0, m_out}, 32'h2222);
        check_eq("bp_new_sel", {30'h0, sel_out}, 32'h1);
        check_eq("bp_cnt", {16'h0, xfer_cnt_out}, 32'd7);
        tick();

        // Fixed priority instance: 1 wins over 2, then 0 wins over all.
        req_in = 3'b110;
        d1_in = 16'hB111; d2_in = 16'hC222;
        out_ready_in = 1'b1;
        settle();
        check_eq("fp_ack_a", {29'h0, fp_ack}, 32'h2);
        tick();
        check_eq("fp_m_a", {16'h0, fp_m}, 32'hB111);
        check_eq("fp_sel_a", {30'h0, fp_sel}, 32'h1);
        check_eq("fp_ack_b", {29'h0, fp_ack}, 32'h2);
        tick();
        check_eq("fp_sel_b", {30'h0, fp_sel}, 32'h1);
        req_in = 3'b111;
        d0_in = 16'hA00F;
        settle();
        check_eq("fp_ack_c", {29'h0, fp_ack}, 32'h1);
        tick();
        check_eq("fp_m_c", {16'h0, fp_m}, 32'hA00F);
        check_eq("fp_sel_c", {30'h0, fp_sel}, 32'h0);
        req_in = 3'b000;
        tick();
        tick();

        // Reset mid-operation discards the held word at once.
        req_in = 3'b001;
        d0_in = 16'h5555;
        out_ready_in = 1'b0;
        tick();
        check_eq("mid_m", {16'h0, m_out}, 32'h5555);
        check_eq("mid_valid", {31'h0, out_valid_out}, 32'h1);
        out_ready_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_m", {16'h0, m_out}, 32'h0);
        check_eq("mid_rst_valid", {31'h0, out_valid_out}, 32'h0);
        check_eq("mid_rst_sel", {30'h0, sel_out}, 32'h3);
        check_eq("mid_rst_cnt", {16'h0, xfer_cnt_out}, 32'h0);
        check_eq("mid_rst_ack", {29'h0, ack_out}, 32'h0);
        tick();
        check_eq("mid_rst_ack2", {29'h0, ack_out}, 32'h0);
        check_eq("mid_rst_valid2", {31'h0, out_valid_out}, 32'h0);

        // Counter wrap: first edge loads, every later edge transfers one word.
        rst_n = 1'b1;
        req_in = 3'b001;
        out_ready_in = 1'b1;
        repeat (65536) tick();
        check_eq("wrap_ffff", {16'h0, xfer_cnt_out}, 32'hFFFF);
        tick();
        check_eq("wrap_zero", {16'h0, xfer_cnt_out}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
